// File: rtl/uart_pkg.sv
// Frame constants and baud helper shared by the UART receiver and transmitter.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   // Whole clock cycles per bit; the fractional remainder is dropped.
   function automatic int unsigned clks_per_bit(input int unsigned freq_hz,
                                                input int unsigned baud);
      return freq_hz / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage shift; resets to the line's idle level so reset never looks like an edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling, one-cycle valid / framing-error strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned BAUDRATE    = 115200
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUDRATE);
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StCleanup,
      StWaitHigh
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [7:0]           byte_q, byte_d;
   logic                 dv_q, dv_d;
   logic                 err_q, err_d;
   logic                 active_q, active_d;
   logic                 rx_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_i (i_Clock),
      .rst_i (i_Reset),
      .d_i   (i_Rx_Serial),
      .q_o   (rx_s)
   );

   // State and datapath registers.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         byte_q   <= 8'h00;
         dv_q     <= 1'b0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         err_q    <= err_d;
         active_q <= active_d;
      end
   end

   // Next-state logic: strobes default low so each lasts exactly one cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      dv_d     = 1'b0;
      err_d    = 1'b0;
      active_d = active_q;

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) begin
               state_d = StStart;
            end
         end

         StStart: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               // Still low at mid-start: genuine start bit, otherwise a glitch.
               if (!rx_s) begin
                  active_d = 1'b1;
                  state_d  = StData;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StData: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StStop: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  dv_d    = 1'b1;
                  state_d = StCleanup;
               end else begin
                  err_d   = 1'b1;
                  state_d = StWaitHigh;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StCleanup: begin
            active_d = 1'b0;
            state_d  = StIdle;
         end

         // A low stop bit may be a break or a stuck line; wait for idle before rearming.
         StWaitHigh: begin
            active_d = 1'b0;
            if (rx_s) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign o_Rx_DV        = dv_q;
   assign o_Rx_Byte      = byte_q;
   assign o_Rx_Frame_Err = err_q;
   assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model with expected byte/timing queue.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ_HZ = 50_000_000;
   localparam int unsigned BAUDRATE    = 115200;
   localparam int CPB      = 434;
   localparam int HALF_BIT = 217;
   // Pin edge to visible strobe: 2 sync stages, 1 idle detect, half bit, 9 full bits.
   localparam int LAT = 3 + HALF_BIT + 9 * CPB;
   localparam int WIN = 3;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         due;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } lit_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       pin;
   logic       dv;
   logic [7:0] rx_byte;
   logic       ferr;
   logic       active;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   dv_seen = 0;
   int   err_seen = 0;
   bit   expect_quiet = 1'b0;
   logic [7:0] model_byte = 8'h00;
   exp_t exp_q[$];
   lit_t lit_q[$];
   exp_t e_cur;
   lit_t l_cur;

   uart_rx #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUDRATE    (BAUDRATE)
   ) dut (
      .i_Clock        (clk),
      .i_Reset        (rst),
      .i_Rx_Serial    (pin),
      .o_Rx_DV        (dv),
      .o_Rx_Byte      (rx_byte),
      .o_Rx_Frame_Err (ferr),
      .o_Rx_Active    (active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single compare process: literal checks plus per-cycle model comparison.
   always @(negedge clk) begin
      while (lit_q.size() > 0) begin
         l_cur = lit_q.pop_front();
         checks++;
         if (l_cur.act !== l_cur.exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", l_cur.name, l_cur.act, l_cur.exp);
         end
      end
      if (rst) begin
         model_byte = 8'h00;
      end else begin
         checks++;
         if (dv && ferr) begin
            errors++;
            $display("FAIL dv_err_exclusive dv=%0b err=%0b cyc=%0d", dv, ferr, cyc);
         end
         if (dv) dv_seen++;
         if (ferr) err_seen++;
         if (dv || ferr) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event dv=%0b err=%0b cyc=%0d expected none", dv, ferr,
                        cyc);
            end else begin
               e_cur = exp_q.pop_front();
               if (ferr != e_cur.is_err) begin
                  errors++;
                  $display("FAIL event_kind err=%0b expected err=%0b cyc=%0d", ferr,
                           e_cur.is_err, cyc);
               end
               checks++;
               if (cyc < e_cur.due - WIN || cyc > e_cur.due + WIN) begin
                  errors++;
                  $display("FAIL event_time cyc=%0d expected=%0d", cyc, e_cur.due);
               end
               checks++;
               if (active !== 1'b1) begin
                  errors++;
                  $display("FAIL active_at_frame_end active=%0b expected=1", active);
               end
               if (!e_cur.is_err) model_byte = e_cur.data;
            end
         end
         checks++;
         if (rx_byte !== model_byte) begin
            errors++;
            $display("FAIL rx_byte actual=%02h expected=%02h cyc=%0d", rx_byte, model_byte, cyc);
         end
         if (exp_q.size() > 0 && cyc > exp_q[0].due + WIN) begin
            checks++;
            errors++;
            $display("FAIL missing_event cyc=%0d expected_by=%0d err=%0b", cyc, exp_q[0].due,
                     exp_q[0].is_err);
            void'(exp_q.pop_front());
         end
         if (expect_quiet) begin
            checks++;
            if (active !== 1'b0) begin
               errors++;
               $display("FAIL glitch_active actual=%0b expected=0 cyc=%0d", active, cyc);
            end
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      lit_t l;
      l.name = name;
      l.act  = act;
      l.exp  = exp;
      lit_q.push_back(l);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Behavioural transmitter; entered and left 1 time unit after a rising edge.
   task automatic send(input logic [7:0] b, input logic stop_v);
      exp_t e;
      e.is_err = !stop_v;
      e.data   = b;
      e.due    = cyc + LAT;
      exp_q.push_back(e);
      pin = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         pin = b[i];
         idle(CPB);
      end
      pin = stop_v;
      idle(CPB);
   endtask

   // Start bit plus the first nbits data bits, no expectation: the frame gets cut off.
   task automatic send_partial(input logic [7:0] b, input int nbits);
      pin = 1'b0;
      idle(CPB);
      for (int i = 0; i < nbits; i++) begin
         pin = b[i];
         idle(CPB);
      end
   endtask

   initial begin
      rst = 1'b1;
      pin = 1'b1;
      #1;
      lit("reset_dv", 32'(dv), 32'h0);
      lit("reset_byte", 32'(rx_byte), 32'h0);
      lit("reset_err", 32'(ferr), 32'h0);
      lit("reset_active", 32'(active), 32'h0);
      idle(3);
      rst = 1'b0;
      idle(20);

      send(8'hA5, 1'b1);
      idle(500);
      lit("byte_a5", 32'(rx_byte), 32'hA5);

      // Back-to-back, no idle gap.
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      idle(500);
      lit("byte_ff", 32'(rx_byte), 32'hFF);

      expect_quiet = 1'b1;
      pin = 1'b0;
      idle(100);
      pin = 1'b1;
      idle(1000);
      expect_quiet = 1'b0;

      // Low stop bit, then line held low 2000 more cycles.
      send(8'h3C, 1'b0);
      idle(1000);
      lit("active_wait_high", 32'(active), 32'h0);
      idle(1000);
      pin = 1'b1;
      idle(500);
      lit("byte_kept_after_ferr", 32'(rx_byte), 32'hFF);
      send(8'h5A, 1'b1);
      idle(500);
      lit("byte_5a", 32'(rx_byte), 32'h5A);

      // Reset after data bit 3; the sender is aborted along with it.
      send_partial(8'hC3, 4);
      lit("active_mid_frame", 32'(active), 32'h1);
      #3;
      rst = 1'b1;
      pin = 1'b1;
      #1;
      lit("midrst_dv", 32'(dv), 32'h0);
      lit("midrst_byte", 32'(rx_byte), 32'h0);
      lit("midrst_err", 32'(ferr), 32'h0);
      lit("midrst_active", 32'(active), 32'h0);
      idle(3);
      rst = 1'b0;
      idle(1000);
      send(8'h81, 1'b1);
      idle(500);
      lit("byte_81", 32'(rx_byte), 32'h81);

      // Loopback sweep across the byte range, back-to-back.
      for (int i = 0; i < 6; i++) begin
         send(8'(i * 51), 1'b1);
      end
      idle(500);
      lit("byte_last_loop", 32'(rx_byte), 32'hFF);

      lit("dv_total", 32'(dv_seen), 32'd11);
      lit("ferr_total", 32'(err_seen), 32'd1);
      lit("pending_events", 32'(exp_q.size()), 32'd0);
      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout cyc=%0d limit=100000", cyc);
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity. Double-synchronizes the asynchronous RX pin, qualifies the start bit at mid-bit, samples each bit at its centre, and presents each good byte with a one-cycle valid strobe. Bad stop bits are reported as framing errors. Sits between the board RX pin and the byte-level command logic, as the receive counterpart of the fabric's UART transmitter at the same baud rate.

## Interface

Parameters:
- CLK_FREQ_HZ, 50_000_000, frequency of i_Clock in Hz.
- BAUDRATE, 115200, line rate in bit/s.
- Derived: CLKS_PER_BIT = CLK_FREQ_HZ/BAUDRATE (integer division), HALF_BIT = CLKS_PER_BIT/2; counter width $clog2(CLKS_PER_BIT).

Ports:
- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  reset; asynchronous, active-high.
- i_Rx_Serial  in  1  asynchronous serial line, idle high.
- o_Rx_DV  out  1  one-cycle strobe, o_Rx_Byte valid.
- o_Rx_Byte  out  8  last good byte; holds until the next good byte.
- o_Rx_Frame_Err  out  1  one-cycle strobe, stop bit sampled low.
- o_Rx_Active  out  1  high from start-bit qualification to frame end.

## Operation

- Reset values: o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Frame_Err=0, o_Rx_Active=0, both sync flops=1, state=s_IDLE, counters=0.
- The input passes through a 2-flop synchronizer; all logic uses the synchronized bit rx_s.
- s_IDLE: counters cleared. rx_s==0 -> s_RX_START_BIT.
- s_RX_START_BIT: count to HALF_BIT-1, then sample rx_s. If 0: o_Rx_Active<=1, clear counter, -> s_RX_DATA_BITS. If 1: glitch, -> s_IDLE with no output.
- s_RX_DATA_BITS: count to CLKS_PER_BIT-1, sample rx_s into shift[bit_idx], clear counter. After bit_idx==7 -> s_RX_STOP_BIT.
- s_RX_STOP_BIT: count to CLKS_PER_BIT-1, sample. If 1: o_Rx_Byte<=shift, o_Rx_DV<=1 -> s_CLEANUP. If 0: o_Rx_Frame_Err<=1, byte discarded, -> s_WAIT_HIGH.
- s_CLEANUP: one cycle. DV/Err drop, o_Rx_Active<=0, -> s_IDLE.
- s_WAIT_HIGH: o_Rx_Active<=0. Stays until rx_s==1 (break or stuck-low line), then -> s_IDLE.
- Undefined state encodings go to s_IDLE.
- o_Rx_DV and o_Rx_Frame_Err are never high together.

## Timing

- Synchronizer latency: 2 cycles from pin to rx_s.
- Sample points: start at HALF_BIT, data bit n at HALF_BIT+(n+1)*CLKS_PER_BIT, stop at HALF_BIT+9*CLKS_PER_BIT cycles after rx_s falls. Each count includes the one sample cycle.
- DV/Err rise one cycle after the stop-bit sample, then last exactly one cycle.
- Return to s_IDLE happens near mid stop bit. A start edge arriving right after the stop bit is caught, so back-to-back frames with no idle gap are received.
- A low pulse shorter than about HALF_BIT on rx_s is rejected. The line must be low at the mid-start sample.
- Reset asserted mid-frame: all outputs clear immediately; the partial byte is lost. After release, a line still low is treated as a start edge. A frame in flight may then yield one framing error; that is accepted behaviour.
- No backpressure. The consumer must capture o_Rx_Byte within one frame time (10*CLKS_PER_BIT cycles).

## Structure

- Shared package uart_pkg: frame constants (DATA_BITS=8, STOP_BITS=1) and a clks_per_bit(freq, baud) function, shared with the transmitter.
- State encodings stay local to this module.
- Sub-module sync_2ff: 2-flop synchronizer, reset value 1, reusable for other async inputs.

## Test plan

Bench parameters: CLK_FREQ_HZ=50_000_000, BAUDRATE=115200 -> CLKS_PER_BIT=434, HALF_BIT=217.

- Single frame 8'hA5 driven on the pin -> one o_Rx_DV pulse, o_Rx_Byte=8'hA5, DV rising about 4125 cycles after the falling edge; o_Rx_Err stays 0.
- Back-to-back 8'h00 then 8'hFF with no idle gap -> two DV pulses, bytes 00 then FF, about 4340 cycles apart.
- 100-cycle low glitch on an idle line -> no DV, no Err, o_Rx_Active never high, state back in s_IDLE.
- Frame 8'h3C with stop bit driven low, line held low a further 2000 cycles -> one Err pulse, no DV, o_Rx_Byte unchanged. A following good 8'h5A is received only after the line returns high.
- i_Reset pulsed after data bit 3 of 8'hC3 -> outputs clear within the reset cycle, no DV for that frame. The next clean frame 8'h81 is received correctly.
- Loopback from the fabric transmitter at the same parameters, 256 bytes 00..FF -> all received in order, zero framing errors.
